poly_voice_synth: RTL and testbench

Parametrised multi-voice synthesizer core. It is the successor to the fixed 8-voice square-only mixer. A single time-multiplexed datapath runs per-voice DDS phase accumulators, selectable per-voice waveforms, per-voice gain and saturating mixing. Once per sample tick it produces one signed mixed sample, which feeds the downstream low-pass filter bank and the audio output stage.

---
 rtl/poly_voice_synth.sv | 151 +++++++++++++++
 tb/tb_poly_voice_synth.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_synth.sv
// Multi-voice DDS synthesizer core: one time-multiplexed datapath walks all voices
// per sample tick, shaping, scaling and summing them into one saturated sample.
module poly_voice_synth #(
  parameter int N_VOICES = 8,
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 16,
  parameter int VOL_W    = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              sample_tick,
  input  logic [N_VOICES-1:0]               voice_enable,
  input  logic [N_VOICES*PHASE_W-1:0]       freq_words,
  input  logic [N_VOICES*2-1:0]             wave_sel,
  input  logic [N_VOICES*8-1:0]             pulse_duty,
  input  logic [N_VOICES*(VOL_W+1)-1:0]     volumes,
  input  logic                              clear_overrun,
  output logic signed [SAMPLE_W-1:0]        out,
  output logic                              out_valid,
  output logic                              busy,
  output logic                              overrun
);

  // state | meaning
  // IDLE  | waiting for sample_tick
  // FETCH | shape voice v, latch its gain/gate, advance its phase
  // ACC   | scale voice v and add it to the running sum
  // DONE  | saturated sum presented on out, out_valid high
  typedef enum logic [1:0] {IDLE, FETCH, ACC, DONE} state_t;

  localparam int VIDX_W = $clog2(N_VOICES);
  localparam int ACC_W  = SAMPLE_W + VOL_W + $clog2(N_VOICES) + 1;
  localparam int PROD_W = SAMPLE_W + VOL_W + 2;
  localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(N_VOICES - 1);
  localparam logic signed [SAMPLE_W-1:0] MAX_S = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] NEG_MAX_S = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};
  localparam logic [SAMPLE_W-1:0] MSB_FLIP = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  state_t                      state;
  logic [VIDX_W-1:0]           v;
  logic [PHASE_W-1:0]          phase [N_VOICES];
  logic signed [ACC_W-1:0]     acc;
  logic signed [SAMPLE_W-1:0]  wave_r;
  logic [VOL_W:0]              vol_r;
  logic                        en_r;

  logic [PHASE_W-1:0]          freq_arr [N_VOICES];
  logic [1:0]                  sel_arr  [N_VOICES];
  logic [7:0]                  duty_arr [N_VOICES];
  logic [VOL_W:0]              vol_arr  [N_VOICES];

  always_comb begin
    for (int i = 0; i < N_VOICES; i++) begin
      freq_arr[i] = freq_words[i*PHASE_W +: PHASE_W];
      sel_arr[i]  = wave_sel[i*2 +: 2];
      duty_arr[i] = pulse_duty[i*8 +: 8];
      vol_arr[i]  = volumes[i*(VOL_W+1) +: (VOL_W+1)];
    end
  end

  function automatic logic signed [SAMPLE_W-1:0] waveform(
    input logic [PHASE_W-1:0] ph,
    input logic [1:0]         sel,
    input logic [7:0]         duty
  );
    logic [SAMPLE_W-1:0] t;
    logic [SAMPLE_W-1:0] u;
    t = ph[PHASE_W-2 -: SAMPLE_W];
    u = ph[PHASE_W-1] ? ~t : t;
    case (sel)
      2'd0:    waveform = ph[PHASE_W-1] ? NEG_MAX_S : MAX_S;
      2'd1:    waveform = $signed(ph[PHASE_W-1 -: SAMPLE_W] ^ MSB_FLIP);
      2'd2:    waveform = $signed(u ^ MSB_FLIP);
      default: waveform = (ph[PHASE_W-1 -: 8] < duty) ? MAX_S : NEG_MAX_S;
    endcase
  endfunction

  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   scaled;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [SAMPLE_W-1:0] sat;
  logic                       ovr_set;

  always_comb begin
    prod     = PROD_W'(wave_r) * PROD_W'($signed({1'b0, vol_r}));
    scaled   = prod >>> VOL_W;
    acc_next = en_r ? (acc + ACC_W'(scaled)) : acc;
    if (acc_next > SAT_HI)      sat = MAX_S;
    else if (acc_next < SAT_LO) sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
    else                        sat = acc_next[SAMPLE_W-1:0];
  end

  // A tick landing in any non-IDLE state (DONE included) is dropped and flagged.
  assign ovr_set = sample_tick && (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      v         <= '0;
      acc       <= '0;
      wave_r    <= '0;
      vol_r     <= '0;
      en_r      <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < N_VOICES; i++) phase[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (ovr_set)            overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            v     <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          wave_r   <= waveform(phase[v], sel_arr[v], duty_arr[v]);
          vol_r    <= vol_arr[v];
          en_r     <= voice_enable[v];
          phase[v] <= voice_enable[v] ? (phase[v] + freq_arr[v]) : '0;
          state    <= ACC;
        end
        ACC: begin
          acc <= acc_next;
          if (v == LAST_V) begin
            out       <= sat;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            v     <= v + VIDX_W'(1);
            state <= FETCH;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_voice_synth.sv
// Directed bench for poly_voice_synth at the default 8-voice configuration.
module tb_poly_voice_synth;
  localparam int NV = 8;
  localparam int PW = 24;
  localparam int SW = 16;
  localparam int VW = 8;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    sample_tick = 1'b0;
  logic [NV-1:0]           voice_enable = '0;
  logic [NV*PW-1:0]        freq_words = '0;
  logic [NV*2-1:0]         wave_sel = '0;
  logic [NV*8-1:0]         pulse_duty = '0;
  logic [NV*(VW+1)-1:0]    volumes = '0;
  logic                    clear_overrun = 1'b0;
  logic signed [SW-1:0]    out;
  logic                    out_valid;
  logic                    busy;
  logic                    overrun;

  int checks = 0;
  int failures = 0;

  poly_voice_synth #(.N_VOICES(NV), .PHASE_W(PW), .SAMPLE_W(SW), .VOL_W(VW)) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
    .voice_enable(voice_enable), .freq_words(freq_words), .wave_sel(wave_sel),
    .pulse_duty(pulse_duty), .volumes(volumes), .clear_overrun(clear_overrun),
    .out(out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_voice(input int vi, input logic en, input int freq,
                           input int wave, input int duty, input int vol);
    voice_enable[vi]           = en;
    freq_words[vi*PW +: PW]    = PW'(freq);
    wave_sel[vi*2 +: 2]        = 2'(wave);
    pulse_duty[vi*8 +: 8]      = 8'(duty);
    volumes[vi*(VW+1) +: VW+1] = (VW+1)'(vol);
  endtask

  task automatic clear_voices();
    for (int i = 0; i < NV; i++) set_voice(i, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Returns the cycle count from the tick cycle to out_valid (100 = timed out).
  task automatic do_tick(output int lat);
    @(posedge clk); #1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic sample_check(input string tag, input int exp);
    int lat;
    do_tick(lat);
    check_int({tag, "_latency"}, lat, 17);
    check_int(tag, $signed(out), exp);
  endtask

  int tri_exp [8] = '{-32768, -16384, 0, 16384, 32767, 16383, -1, -16385};
  int sq_exp  [4] = '{32767, 32767, -32767, -32767};
  int pul_exp [4] = '{32767, -32767, -32767, -32767};

  initial begin
    int pulses;
    int pulse_cyc;
    int lat;

    // Reset state, then abort a computation with reset.
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_int("rst_out", $signed(out), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_overrun", int'(overrun), 0);
    set_voice(0, 1'b1, 1 << 22, 0, 0, 256);
    sample_check("pre_abort", 32767);
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("mid_busy", int'(busy), 1);
    check_int("mid_overrun", int'(overrun), 1);
    reset_n = 1'b0;
    #1;
    check_int("abort_out", $signed(out), 0);
    check_int("abort_valid", int'(out_valid), 0);
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_overrun", int'(overrun), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check_int("abort_no_valid", pulses, 0);
    sample_check("post_reset_phase0", 32767);

    // Square wave on voice 0.
    do_reset();
    for (int i = 0; i < 4; i++) sample_check($sformatf("square_%0d", i), sq_exp[i]);

    // Triangle on voice 3.
    do_reset();
    clear_voices();
    set_voice(3, 1'b1, 1 << 21, 2, 0, 256);
    for (int i = 0; i < 8; i++) sample_check($sformatf("tri_%0d", i), tri_exp[i]);

    // Gain and saturation.
    do_reset();
    clear_voices();
    set_voice(0, 1'b1, 0, 1, 0, 128);
    sample_check("saw_half_gain", -16384);
    for (int i = 0; i < NV; i++) set_voice(i, 1'b1, 0, 0, 0, 256);
    sample_check("sat_pos", 32767);
    for (int i = 0; i < NV; i++) set_voice(i, 1'b1, 0, 1, 0, 256);
    sample_check("sat_neg", -32768);

    // Overrun: ticks at cycle 0 and 5.
    do_reset();
    clear_voices();
    set_voice(0, 1'b1, 0, 0, 0, 256);
    @(posedge clk); #1 sample_tick = 1'b1;
    pulses = 0;
    pulse_cyc = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      sample_tick = (c == 5);
      if (out_valid) begin
        pulses++;
        pulse_cyc = c;
      end
      if (c == 18) check_int("busy_after_done", int'(busy), 0);
    end
    check_int("ovr_pulses", pulses, 1);
    check_int("ovr_pulse_cycle", pulse_cyc, 17);
    check_int("ovr_flag", int'(overrun), 1);
    clear_overrun = 1'b1;
    @(posedge clk); #1 clear_overrun = 1'b0;
    check_int("ovr_cleared", int'(overrun), 0);
    sample_tick = 1'b1;
    @(posedge clk); #1 clear_overrun = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    clear_overrun = 1'b0;
    check_int("ovr_set_wins", int'(overrun), 1);
    repeat (20) @(posedge clk);
    #1 clear_overrun = 1'b1;
    @(posedge clk); #1 clear_overrun = 1'b0;

    // Gate retrigger, then pulse wave.
    do_reset();
    clear_voices();
    set_voice(0, 1'b1, 1 << 22, 0, 0, 256);
    sample_check("gate_s0", 32767);
    sample_check("gate_s1", 32767);
    voice_enable[0] = 1'b0;
    sample_check("gate_off", 0);
    voice_enable[0] = 1'b1;
    sample_check("gate_retrig0", 32767);
    sample_check("gate_retrig1", 32767);
    sample_check("gate_retrig2", -32767);
    do_reset();
    set_voice(0, 1'b1, 1 << 22, 3, 64, 256);
    for (int i = 0; i < 4; i++) sample_check($sformatf("pulse_%0d", i), pul_exp[i]);
    set_voice(0, 1'b1, 1 << 22, 3, 0, 256);
    sample_check("pulse_duty0", -32767);

    do_tick(lat);
    check_int("final_latency", lat, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
